// File: rtl/seq_multiplier_pkg.sv
// seq_multiplier_pkg: FSM state type and sizing helpers for seq_multiplier
package seq_multiplier_pkg;
    localparam int STATE_W = 2;
    typedef enum logic [STATE_W-1:0] {IDLE, RUN, DONE} state_t;
    function automatic int cnt_w(input int w);
        return $clog2(w);
    endfunction
endpackage

// File: rtl/seq_multiplier_if.sv
// seq_multiplier_if: operand/result valid-ready handshake bundle
interface seq_multiplier_if #(parameter int WIDTH = 8);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   product;
    logic                 busy;
    modport master(output in_valid, a, b, out_ready, input in_ready, out_valid, product, busy);
    modport slave(input in_valid, a, b, out_ready, output in_ready, out_valid, product, busy);
endinterface

// File: rtl/seq_multiplier_ripple_adder_n.sv
// ripple_adder_n: N-bit ripple-carry adder with carry-in and carry-out
module ripple_adder_n #(parameter int N = 8) (
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    input  logic         ci,
    output logic [N-1:0] s,
    output logic         co
);
    logic [N:0] c;
    assign c[0] = ci;
    for (genvar i = 0; i < N; i++) begin : g_bit
        assign s[i]   = x[i] ^ y[i] ^ c[i];
        assign c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
    end
    assign co = c[N];
endmodule

// File: rtl/seq_multiplier.sv
// seq_multiplier: iterative shift-and-add multiplier; SEQ_MULTIPLIER_SIGNED_EN selects two's complement operands
module seq_multiplier
    import seq_multiplier_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input logic          clk,
    input logic          rst,
    seq_multiplier_if.slave bus
);
    localparam int CW = cnt_w(WIDTH);
    state_t state_q, state_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
    logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] addend, sum, op_a, op_b;
    logic             carry;
    assign addend = acc_lo_q[0] ? mcand_q : '0;
    ripple_adder_n #(.N(WIDTH)) u_add (.x(acc_hi_q), .y(addend), .ci(1'b0), .s(sum), .co(carry));
`ifdef SEQ_MULTIPLIER_SIGNED_EN
    logic neg_q, neg_d;
    // the most-negative value negates to itself, which is its correct unsigned magnitude
    assign op_a = bus.a[WIDTH-1] ? -bus.a : bus.a;
    assign op_b = bus.b[WIDTH-1] ? -bus.b : bus.b;
    assign bus.product = neg_q ? -{acc_hi_q, acc_lo_q} : {acc_hi_q, acc_lo_q};
`else
    assign op_a = bus.a;
    assign op_b = bus.b;
    assign bus.product = {acc_hi_q, acc_lo_q};
`endif
    assign bus.in_ready  = state_q == IDLE;
    assign bus.out_valid = state_q == DONE;
    assign bus.busy      = state_q != IDLE;
    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        count_d  = count_q;
`ifdef SEQ_MULTIPLIER_SIGNED_EN
        neg_d    = neg_q;
`endif
        if (state_q == IDLE && bus.in_valid) begin
            state_d  = RUN;
            mcand_d  = op_a;
            acc_hi_d = '0;
            acc_lo_d = op_b;
            count_d  = '0;
`ifdef SEQ_MULTIPLIER_SIGNED_EN
            neg_d    = bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
`endif
        end else if (state_q == RUN) begin
            {acc_hi_d, acc_lo_d} = {carry, sum, acc_lo_q[WIDTH-1:1]};
            count_d = count_q + 1'b1;
            state_d = count_q == CW'(WIDTH - 1) ? DONE : RUN;
        end else if (state_q == DONE && bus.out_ready) begin
            state_d = IDLE;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            mcand_q  <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            count_q  <= '0;
`ifdef SEQ_MULTIPLIER_SIGNED_EN
            neg_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            count_q  <= count_d;
`ifdef SEQ_MULTIPLIER_SIGNED_EN
            neg_q    <= neg_d;
`endif
        end
    end
endmodule
